// File: rtl/note_entry_if.sv
// Signal bundle between the note-entry front end and whoever drives the raw switches
// and consumes the clean ok/tone/note outputs.
interface note_entry_if;
    logic       ok_raw;
    logic       tone_sw;
    logic [2:0] note_sw;
    logic       ok;
    logic       tone;
    logic [2:0] note;
    logic       busy;
    logic [3:0] note_count;

    modport master (
        output ok_raw, tone_sw, note_sw,
        input  ok, tone, note, busy, note_count
    );

    modport slave (
        input  ok_raw, tone_sw, note_sw,
        output ok, tone, note, busy, note_count
    );
endinterface

// File: rtl/note_entry.sv
// Note-entry front end: synchronizes raw switches, debounces the confirm button and emits
// one clean ok pulse per accepted press/release, with tone/note latched ahead of the pulse.
module note_entry #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned PULSE_LEN = 2
) (
    input logic         clk,
    input logic         reset,
    note_entry_if.slave bus
);

    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : gen_bad_db_cycles
        $error("note_entry: DB_CYCLES must be within 2..65535");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : gen_bad_pulse_len
        $error("note_entry: PULSE_LEN must be within 1..255");
    end

    localparam logic [15:0] DbLast    = 16'(DB_CYCLES - 1);
    localparam logic [7:0]  PulseLast = 8'(PULSE_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb,
        StSetup,
        StPulse,
        StHold
    } state_e;

    logic       ok_meta_q, ok_s_q;
    logic       tone_meta_q, tone_s_q;
    logic [2:0] note_meta_q, note_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_meta_q   <= 1'b0;
            ok_s_q      <= 1'b0;
            tone_meta_q <= 1'b0;
            tone_s_q    <= 1'b0;
            note_meta_q <= 3'b000;
            note_s_q    <= 3'b000;
        end else begin
            ok_meta_q   <= bus.ok_raw;
            ok_s_q      <= ok_meta_q;
            tone_meta_q <= bus.tone_sw;
            tone_s_q    <= tone_meta_q;
            note_meta_q <= bus.note_sw;
            note_s_q    <= note_meta_q;
        end
    end

    state_e      state_q;
    logic [15:0] db_cnt_q;
    logic [7:0]  pulse_cnt_q;
    logic        ok_q;
    logic        busy_q;
    logic        tone_q;
    logic [2:0]  note_q;
    logic [3:0]  count_q;

    logic [15:0] db_cnt_inc;
    assign db_cnt_inc = db_cnt_q + 16'd1;

    // The debounce window includes the sample that entered PRESS_DB/RELEASE_DB, so the
    // incremented count is what reaches DB_CYCLES-1 on the last stable sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            db_cnt_q    <= 16'd0;
            pulse_cnt_q <= 8'd0;
            ok_q        <= 1'b0;
            busy_q      <= 1'b0;
            tone_q      <= 1'b0;
            note_q      <= 3'b000;
            count_q     <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ok_s_q) begin
                        state_q  <= StPressDb;
                        db_cnt_q <= 16'd0;
                        busy_q   <= 1'b1;
                    end
                end
                StPressDb: begin
                    if (!ok_s_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_inc;
                        if (db_cnt_inc == DbLast) begin
                            state_q <= StHeld;
                        end
                    end
                end
                StHeld: begin
                    if (!ok_s_q) begin
                        state_q  <= StReleaseDb;
                        db_cnt_q <= 16'd0;
                    end
                end
                StReleaseDb: begin
                    if (ok_s_q) begin
                        state_q <= StHeld;
                    end else begin
                        db_cnt_q <= db_cnt_inc;
                        if (db_cnt_inc == DbLast) begin
                            tone_q  <= tone_s_q;
                            note_q  <= note_s_q;
                            state_q <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    state_q     <= StPulse;
                    pulse_cnt_q <= 8'd0;
                    ok_q        <= 1'b1;
                end
                StPulse: begin
                    if (pulse_cnt_q == PulseLast) begin
                        ok_q    <= 1'b0;
                        state_q <= StHold;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 8'd1;
                    end
                end
                StHold: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (count_q != 4'd15) begin
                        count_q <= count_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ok_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ok         = ok_q;
    assign bus.tone       = tone_q;
    assign bus.note       = note_q;
    assign bus.busy       = busy_q;
    assign bus.note_count = count_q;

endmodule
